// File: rtl/elbeth_alu_issue.sv
// Issue stage for elbeth_alu: decodes RV32I OP / OP-IMM / LUI / AUIPC into ALU operands and opcode.
// Optional statistics counters are enabled by defining ELBETH_ISSUE_STATS_EN.
module elbeth_alu_issue #(
   parameter int STAT_WIDTH = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_pc,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] data_a,
   output logic [31:0] data_b,
   output logic [3:0]  operation,
   output logic [4:0]  rd_addr,
   output logic        rd_we,
   output logic        illegal
`ifdef ELBETH_ISSUE_STATS_EN
   ,
   output logic [STAT_WIDTH-1:0] issue_count,
   output logic [STAT_WIDTH-1:0] stall_count
`endif
);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_SLL  = 4'd2;
   localparam logic [3:0] OP_SLT  = 4'd3;
   localparam logic [3:0] OP_SLTU = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_SRL  = 4'd6;
   localparam logic [3:0] OP_SRA  = 4'd7;
   localparam logic [3:0] OP_OR   = 4'd8;
   localparam logic [3:0] OP_AND  = 4'd9;

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;

   // Handshake: a transfer happens on a rising edge where valid & ready are both high;
   // valid never depends on ready, and flush suppresses any same-cycle transfer into the stage.
   logic accept;
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready && !flush;

   logic [6:0]  opcode;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm_i;
   logic [31:0] imm_u;
   assign opcode = in_instr[6:0];
   assign f3     = in_instr[14:12];
   assign f7     = in_instr[31:25];
   assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
   assign imm_u  = {in_instr[31:12], 12'b0};

   logic [31:0] dec_a;
   logic [31:0] dec_b;
   logic [3:0]  dec_op;
   logic        dec_ill;
   logic [4:0]  dec_rd;
   logic        dec_we;

   always_comb begin
      dec_a   = 32'd0;
      dec_b   = 32'd0;
      dec_op  = OP_ADD;
      dec_ill = 1'b0;
      case (opcode)
         OPC_OP: begin
            dec_a = rs1_data;
            dec_b = rs2_data;
            case (f3)
               3'd0: begin
                  dec_op  = (f7 == 7'b0100000) ? OP_SUB : OP_ADD;
                  dec_ill = (f7 != 7'b0000000) && (f7 != 7'b0100000);
               end
               3'd1: begin
                  dec_op  = OP_SLL;
                  dec_b   = {27'b0, rs2_data[4:0]};
                  dec_ill = (f7 != 7'b0000000);
               end
               3'd2: begin dec_op = OP_SLT;  dec_ill = (f7 != 7'b0000000); end
               3'd3: begin dec_op = OP_SLTU; dec_ill = (f7 != 7'b0000000); end
               3'd4: begin dec_op = OP_XOR;  dec_ill = (f7 != 7'b0000000); end
               3'd5: begin
                  dec_op  = (f7 == 7'b0100000) ? OP_SRA : OP_SRL;
                  dec_b   = {27'b0, rs2_data[4:0]};
                  dec_ill = (f7 != 7'b0000000) && (f7 != 7'b0100000);
               end
               3'd6: begin dec_op = OP_OR;  dec_ill = (f7 != 7'b0000000); end
               default: begin dec_op = OP_AND; dec_ill = (f7 != 7'b0000000); end
            endcase
         end
         OPC_OPIMM: begin
            dec_a = rs1_data;
            dec_b = imm_i;
            case (f3)
               3'd0: dec_op = OP_ADD;
               3'd1: begin
                  dec_op  = OP_SLL;
                  dec_b   = {27'b0, in_instr[24:20]};
                  dec_ill = (f7 != 7'b0000000);
               end
               3'd2: dec_op = OP_SLT;
               3'd3: dec_op = OP_SLTU;
               3'd4: dec_op = OP_XOR;
               3'd5: begin
                  dec_op  = (f7 == 7'b0100000) ? OP_SRA : OP_SRL;
                  dec_b   = {27'b0, in_instr[24:20]};
                  dec_ill = (f7 != 7'b0000000) && (f7 != 7'b0100000);
               end
               3'd6: dec_op = OP_OR;
               default: dec_op = OP_AND;
            endcase
         end
         OPC_LUI: begin
            dec_a = 32'd0;
            dec_b = imm_u;
         end
         OPC_AUIPC: begin
            dec_a = in_pc;
            dec_b = imm_u;
         end
         default: dec_ill = 1'b1;
      endcase
      // Illegal entries still issue, but carry a neutral ALU request.
      if (dec_ill) begin
         dec_a  = 32'd0;
         dec_b  = 32'd0;
         dec_op = OP_ADD;
      end
   end

   assign dec_rd = in_instr[11:7];
   assign dec_we = !dec_ill && (dec_rd != 5'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         data_a    <= 32'd0;
         data_b    <= 32'd0;
         operation <= OP_ADD;
         rd_addr   <= 5'd0;
         rd_we     <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         if (flush)
            out_valid <= 1'b0;
         else if (accept)
            out_valid <= 1'b1;
         else if (out_ready)
            out_valid <= 1'b0;
         if (accept) begin
            data_a    <= dec_a;
            data_b    <= dec_b;
            operation <= dec_op;
            rd_addr   <= dec_rd;
            rd_we     <= dec_we;
            illegal   <= dec_ill;
         end
      end
   end

`ifdef ELBETH_ISSUE_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         issue_count <= '0;
         stall_count <= '0;
      end else begin
         if (accept && !dec_ill)
            issue_count <= issue_count + 1'b1;
         if (out_valid && !out_ready)
            stall_count <= stall_count + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_elbeth_alu_issue.sv
// Self-checking bench for elbeth_alu_issue: directed cases plus randomized traffic against a
// reference decoder and one-entry expected queue.
module tb_elbeth_alu_issue;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_SLL  = 4'd2;
   localparam logic [3:0] OP_SLT  = 4'd3;
   localparam logic [3:0] OP_SLTU = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_SRL  = 4'd6;
   localparam logic [3:0] OP_SRA  = 4'd7;
   localparam logic [3:0] OP_OR   = 4'd8;
   localparam logic [3:0] OP_AND  = 4'd9;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic [31:0] in_instr, in_pc, rs1_data, rs2_data;
   logic        in_ready, out_valid, rd_we, illegal;
   logic [31:0] data_a, data_b;
   logic [3:0]  operation;
   logic [4:0]  rd_addr;
`ifdef ELBETH_ISSUE_STATS_EN
   logic [31:0] issue_count, stall_count;
   logic [31:0] m_issue, m_stall;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
      logic [4:0]  rd;
      logic        we;
      logic        ill;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   elbeth_alu_issue #(.STAT_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .rs1_data(rs1_data), .rs2_data(rs2_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .data_a(data_a), .data_b(data_b), .operation(operation),
      .rd_addr(rd_addr), .rd_we(rd_we), .illegal(illegal)
`ifdef ELBETH_ISSUE_STATS_EN
      , .issue_count(issue_count), .stall_count(stall_count)
`endif
   );

   // Reference decoder written from the instruction-set rules.
   function automatic exp_t ref_decode(input logic [31:0] instr, input logic [31:0] pc,
                                       input logic [31:0] r1, input logic [31:0] r2);
      exp_t e;
      int opc, f3, f7;
      logic [31:0] imm;
      opc = int'(instr[6:0]);
      f3  = int'(instr[14:12]);
      f7  = int'(instr[31:25]);
      imm = {{20{instr[31]}}, instr[31:20]};
      e = '0;
      e.op = OP_ADD;
      if (opc == 'h33) begin
         e.a = r1;
         e.b = (f3 == 1 || f3 == 5) ? (r2 % 32) : r2;
         e.ill = !(f7 == 0 || (f7 == 'h20 && (f3 == 0 || f3 == 5)));
         case (f3)
            0: e.op = (f7 == 'h20) ? OP_SUB : OP_ADD;
            1: e.op = OP_SLL;
            2: e.op = OP_SLT;
            3: e.op = OP_SLTU;
            4: e.op = OP_XOR;
            5: e.op = (f7 == 'h20) ? OP_SRA : OP_SRL;
            6: e.op = OP_OR;
            default: e.op = OP_AND;
         endcase
      end else if (opc == 'h13) begin
         e.a = r1;
         e.b = (f3 == 1 || f3 == 5) ? 32'(instr[24:20]) : imm;
         e.ill = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 'h20);
         case (f3)
            0: e.op = OP_ADD;
            1: e.op = OP_SLL;
            2: e.op = OP_SLT;
            3: e.op = OP_SLTU;
            4: e.op = OP_XOR;
            5: e.op = (f7 == 'h20) ? OP_SRA : OP_SRL;
            6: e.op = OP_OR;
            default: e.op = OP_AND;
         endcase
      end else if (opc == 'h37) begin
         e.a = 0;
         e.b = instr & 32'hFFFF_F000;
      end else if (opc == 'h17) begin
         e.a = pc;
         e.b = instr & 32'hFFFF_F000;
      end else begin
         e.ill = 1'b1;
      end
      if (e.ill) begin
         e.a = 0;
         e.b = 0;
         e.op = OP_ADD;
      end
      e.rd = instr[11:7];
      e.we = !e.ill && (e.rd != 0);
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      int k, s;
      w = $urandom;
      k = int'($urandom_range(0, 9));
      s = int'($urandom_range(0, 3));
      if (k <= 2)      w[6:0] = 7'h33;
      else if (k <= 5) w[6:0] = 7'h13;
      else if (k == 6) w[6:0] = 7'h37;
      else if (k == 7) w[6:0] = 7'h17;
      if (k <= 5 && s <= 1) w[31:25] = 7'h00;
      else if (k <= 5 && s == 2) w[31:25] = 7'h20;
      return w;
   endfunction

   task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] r1, input logic [31:0] r2,
                        input logic ordy, input logic fl);
      @(negedge clk);
      in_valid  = v;
      in_instr  = instr;
      in_pc     = pc;
      rs1_data  = r1;
      rs2_data  = r2;
      out_ready = ordy;
      flush     = fl;
      #1;
   endtask

   // Advance one clock and move the expected queue the way the stage should.
   task automatic tick();
      logic mv, acc;
      exp_t d;
      @(posedge clk);
      mv  = (exp_q.size() != 0);
      acc = in_valid && (!mv || out_ready) && !flush;
      d   = ref_decode(in_instr, in_pc, rs1_data, rs2_data);
`ifdef ELBETH_ISSUE_STATS_EN
      if (rst) begin
         m_issue = 0;
         m_stall = 0;
      end else begin
         if (mv && !out_ready) m_stall++;
         if (acc && !d.ill) m_issue++;
      end
`endif
      if (rst || flush) exp_q.delete();
      else begin
         if (mv && out_ready) void'(exp_q.pop_front());
         if (acc) exp_q.push_back(d);
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b1, 32'h002081B3, 0, 1, 2, 1'b0, 1'b0);
      tick();
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_checks++; if (data_a !== 32'd0 || data_b !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h/%h want 0/0", data_a, data_b); end
      n_checks++; if (operation !== OP_ADD || rd_addr !== 5'd0 || rd_we !== 1'b0 || illegal !== 1'b0) begin
         n_fail++; $display("FAIL reset_ctrl: got op=%0d rd=%0d we=%b ill=%b want 0/0/0/0", operation, rd_addr, rd_we, illegal); end
      rst = 1'b0;
      drive(1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
`ifdef ELBETH_ISSUE_STATS_EN
      n_checks++; if (issue_count !== 0 || stall_count !== 0) begin n_fail++; $display("FAIL reset_stats: got %0d/%0d want 0/0", issue_count, stall_count); end
`endif
   endtask

   task automatic test_directed();
      drive(1'b1, 32'h002081B3, 0, 32'd5, 32'd7, 1'b1, 1'b0);
      tick();
      n_checks++; if (out_valid !== 1'b1 || data_a !== 32'd5 || data_b !== 32'd7 || operation !== OP_ADD || rd_addr !== 5'd3 || rd_we !== 1'b1) begin
         n_fail++; $display("FAIL add: got v=%b a=%h b=%h op=%0d rd=%0d we=%b want 1/5/7/0/3/1", out_valid, data_a, data_b, operation, rd_addr, rd_we); end
      drive(1'b1, 32'h40435293, 0, 32'h8000_0000, 32'h1234, 1'b1, 1'b0);
      tick();
      n_checks++; if (out_valid !== 1'b1 || data_a !== 32'h8000_0000 || data_b !== 32'h4 || operation !== OP_SRA || illegal !== 1'b0 || rd_addr !== 5'd5) begin
         n_fail++; $display("FAIL srai: got v=%b a=%h b=%h op=%0d ill=%b rd=%0d want 1/80000000/4/7/0/5", out_valid, data_a, data_b, operation, illegal, rd_addr); end
      drive(1'b1, 32'h12345097, 32'h100, 32'hDEAD, 32'hBEEF, 1'b1, 1'b0);
      tick();
      n_checks++; if (out_valid !== 1'b1 || data_a !== 32'h100 || data_b !== 32'h1234_5000 || operation !== OP_ADD || rd_addr !== 5'd1) begin
         n_fail++; $display("FAIL auipc: got v=%b a=%h b=%h op=%0d rd=%0d want 1/100/12345000/0/1", out_valid, data_a, data_b, operation, rd_addr); end
      drive(1'b1, 32'h0000007F, 0, 32'h11, 32'h22, 1'b1, 1'b0);
      tick();
      n_checks++; if (out_valid !== 1'b1 || illegal !== 1'b1 || rd_we !== 1'b0 || data_a !== 0 || data_b !== 0 || operation !== OP_ADD) begin
         n_fail++; $display("FAIL illegal: got v=%b ill=%b we=%b a=%h b=%h op=%0d want 1/1/0/0/0/0", out_valid, illegal, rd_we, data_a, data_b, operation); end
      drive(1'b1, 32'h00100013, 0, 32'h0, 32'h0, 1'b1, 1'b0);
      tick();
      n_checks++; if (out_valid !== 1'b1 || illegal !== 1'b0 || rd_we !== 1'b0 || data_b !== 32'd1) begin
         n_fail++; $display("FAIL addi_x0: got v=%b ill=%b we=%b b=%h want 1/0/0/1", out_valid, illegal, rd_we, data_b); end
`ifdef ELBETH_ISSUE_STATS_EN
      n_checks++; if (issue_count !== m_issue) begin n_fail++; $display("FAIL issue_count: got %0d want %0d", issue_count, m_issue); end
`endif
      drive(1'b0, 0, 0, 0, 0, 1'b1, 1'b0);
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain: got %b want 0", out_valid); end
   endtask

   task automatic test_backpressure();
      drive(1'b1, 32'h002081B3, 0, 32'd10, 32'd20, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h40208233, 0, 32'd50, 32'd8, 1'b0, 1'b0);
         n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: cycle %0d got %b want 0", i, in_ready); end
         tick();
         n_checks++; if (out_valid !== 1'b1 || data_a !== 32'd10 || data_b !== 32'd20 || operation !== OP_ADD || rd_addr !== 5'd3) begin
            n_fail++; $display("FAIL bp_hold: cycle %0d got v=%b a=%h b=%h op=%0d rd=%0d want 1/a/14/0/3", i, out_valid, data_a, data_b, operation, rd_addr); end
      end
      drive(1'b1, 32'h40208233, 0, 32'd50, 32'd8, 1'b1, 1'b0);
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
      tick();
      n_checks++; if (out_valid !== 1'b1 || data_a !== 32'd50 || data_b !== 32'd8 || operation !== OP_SUB || rd_addr !== 5'd4) begin
         n_fail++; $display("FAIL bp_next: got v=%b a=%h b=%h op=%0d rd=%0d want 1/32/8/1/4", out_valid, data_a, data_b, operation, rd_addr); end
`ifdef ELBETH_ISSUE_STATS_EN
      n_checks++; if (stall_count !== m_stall) begin n_fail++; $display("FAIL stall_count: got %0d want %0d", stall_count, m_stall); end
`endif
   endtask

   task automatic test_flush();
      drive(1'b1, 32'h002081B3, 0, 32'd1, 32'd1, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'h00310233, 0, 32'd2, 32'd3, 1'b1, 1'b1);
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", out_valid); end
      drive(1'b0, 0, 0, 0, 0, 1'b0, 1'b1);
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_empty_ready: got %b want 1", in_ready); end
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty: got %b want 0", out_valid); end
   endtask

   task automatic test_random();
      exp_t e;
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom, $urandom,
               $urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0);
         n_checks++; if (in_ready !== ((exp_q.size() == 0) || out_ready)) begin
            n_fail++; $display("FAIL rand_in_ready: cycle %0d got %b want %b", i, in_ready, (exp_q.size() == 0) || out_ready); end
         tick();
         n_checks++; if (out_valid !== (exp_q.size() != 0)) begin
            n_fail++; $display("FAIL rand_valid: cycle %0d got %b want %b", i, out_valid, exp_q.size() != 0); end
         if (exp_q.size() != 0) begin
            e = exp_q[0];
            n_checks++; if (data_a !== e.a || data_b !== e.b || operation !== e.op || rd_addr !== e.rd || rd_we !== e.we || illegal !== e.ill) begin
               n_fail++; $display("FAIL rand_data: cycle %0d instr=%h got a=%h b=%h op=%0d rd=%0d we=%b ill=%b want a=%h b=%h op=%0d rd=%0d we=%b ill=%b",
                  i, in_instr, data_a, data_b, operation, rd_addr, rd_we, illegal, e.a, e.b, e.op, e.rd, e.we, e.ill); end
         end
`ifdef ELBETH_ISSUE_STATS_EN
         n_checks++; if (issue_count !== m_issue || stall_count !== m_stall) begin
            n_fail++; $display("FAIL rand_stats: cycle %0d got %0d/%0d want %0d/%0d", i, issue_count, stall_count, m_issue, m_stall); end
`endif
      end
   endtask

   task automatic test_reset_midflight();
      drive(1'b1, 32'h002081B3, 0, 32'd9, 32'd9, 1'b0, 1'b0);
      tick();
      rst = 1'b1;
      drive(1'b1, 32'h002081B3, 0, 32'd9, 32'd9, 1'b0, 1'b0);
      tick();
      rst = 1'b0;
      drive(1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
      n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_mid: got v=%b rdy=%b want 0/1", out_valid, in_ready); end
      tick();
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = 0; in_pc = 0; rs1_data = 0; rs2_data = 0;
`ifdef ELBETH_ISSUE_STATS_EN
      m_issue = 0; m_stall = 0;
`endif
      test_reset();
      test_directed();
      test_backpressure();
      test_flush();
      test_random();
      test_reset_midflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
